// File: rtl/dac_module.sv
// dac_module: buffers 12-bit playback samples arriving on a valid/ready
// handshake in the clk_PSRAM domain. It divides clk_PSRAM down to the DAC
// sample clock and presents one sample per clk_DAC period. Each new sample is
// launched on the clk_DAC falling edge, so it is stable at the rising edge.
module dac_module #(
   parameter int                DATA_W        = 12,
   parameter int                CLK_DIV       = 4,
   parameter int                FIFO_DEPTH    = 16,
   parameter int                PRIME_SAMPLES = 4,
   parameter logic [DATA_W-1:0] MIDSCALE      = 12'h800
) (
   input  logic                          clk_PSRAM,
   input  logic                          rst,
   input  logic                          dac_enable,
   input  logic                          dac_valid,
   input  logic [DATA_W-1:0]             dac_in,
   output logic                          dac_ready,
   output logic                          clk_DAC,
   output logic [DATA_W-1:0]             dac_out,
   output logic                          dac_running,
   output logic                          dac_underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(CLK_DIV);

   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_RISE_PRE = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [LVL_W-1:0] LVL_FULL     = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] LVL_PRIME    = LVL_W'(PRIME_SAMPLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_clk_dac;
   logic [DATA_W-1:0]   r_dac_out;
   logic                r_running;
   logic                r_underrun;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [LVL_W-1:0]    r_level;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

   logic                w_ready;
   logic                w_push;
   logic                w_fall;
   logic                w_empty;
   logic                w_pop;
   logic [DATA_W-1:0]   w_head;

   // Handshake, fall-boundary detection and pop decision from registered state.
   always_comb begin
      w_ready = 1'b0;
      w_push  = 1'b0;
      w_fall  = 1'b0;
      w_empty = 1'b0;
      w_pop   = 1'b0;
      w_head  = r_mem[r_rd_ptr];

      w_ready = dac_enable && !rst && (r_level < LVL_FULL);
      w_push  = dac_valid && w_ready;
      w_fall  = (r_state != ST_IDLE) && (r_cnt == CNT_LAST);
      w_empty = (r_level == {LVL_W{1'b0}});

      // Pops only happen at a fall boundary: in RUN whenever data is there,
      // in PRIME only once the buffer has reached the priming level.
      if (!dac_enable) begin
         w_pop = 1'b0;
      end else if (!w_fall) begin
         w_pop = 1'b0;
      end else if (r_state == ST_RUN) begin
         w_pop = !w_empty;
      end else if (r_state == ST_PRIME) begin
         w_pop = (r_level >= LVL_PRIME);
      end else begin
         w_pop = 1'b0;
      end
   end

   // Control FSM, clock divider and registered DAC-side outputs.
   always_ff @(posedge clk_PSRAM) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= {CNT_W{1'b0}};
         r_clk_dac  <= 1'b0;
         r_dac_out  <= MIDSCALE;
         r_running  <= 1'b0;
         r_underrun <= 1'b0;
      end else if (!dac_enable) begin
         // Stop: park the outputs; the underrun flag survives for software.
         r_state    <= ST_IDLE;
         r_cnt      <= {CNT_W{1'b0}};
         r_clk_dac  <= 1'b0;
         r_dac_out  <= MIDSCALE;
         r_running  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state    <= ST_PRIME;
               r_underrun <= 1'b0;
               r_cnt      <= {CNT_W{1'b0}};
               r_clk_dac  <= 1'b0;
               r_dac_out  <= MIDSCALE;
               r_running  <= 1'b0;
            end
            ST_PRIME, ST_RUN: begin
               if (w_fall) begin
                  r_cnt     <= {CNT_W{1'b0}};
                  r_clk_dac <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_RISE_PRE) begin
                     r_clk_dac <= 1'b1;
                  end
               end
               if (w_pop) begin
                  r_dac_out <= w_head;
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end else if (w_fall && (r_state == ST_RUN)) begin
                  // Starved: hold the last code and stay in RUN.
                  r_underrun <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_cnt      <= {CNT_W{1'b0}};
               r_clk_dac  <= 1'b0;
               r_dac_out  <= MIDSCALE;
               r_running  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; stopping playback discards buffered data.
   always_ff @(posedge clk_PSRAM) begin
      if (rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_level  <= {LVL_W{1'b0}};
      end else if (!dac_enable) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_level  <= {LVL_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Sample storage; contents need no reset because the pointers gate them.
   always_ff @(posedge clk_PSRAM) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= dac_in;
      end
   end

   assign dac_ready    = w_ready;
   assign clk_DAC      = r_clk_dac;
   assign dac_out      = r_dac_out;
   assign dac_running  = r_running;
   assign dac_underrun = r_underrun;
   assign fifo_level   = r_level;

endmodule

// File: tb/tb_dac_module.sv
// tb_dac_module: scoreboard bench for dac_module. Accepted samples are queued
// as they are driven. They are popped and compared when the playback output
// is due to change. A cycle-level reference of the divider/FSM is checked
// against every output each cycle, alongside directed checks from the test plan.
module tb_dac_module;

   localparam int                DATA_W        = 12;
   localparam int                CLK_DIV       = 4;
   localparam int                FIFO_DEPTH    = 16;
   localparam int                PRIME_SAMPLES = 4;
   localparam logic [DATA_W-1:0] MIDSCALE      = 12'h800;
   localparam int                LVL_W         = $clog2(FIFO_DEPTH) + 1;

   logic                clk_PSRAM = 1'b0;
   logic                rst;
   logic                dac_enable;
   logic                dac_valid;
   logic [DATA_W-1:0]   dac_in;
   logic                dac_ready;
   logic                clk_DAC;
   logic [DATA_W-1:0]   dac_out;
   logic                dac_running;
   logic                dac_underrun;
   logic [LVL_W-1:0]    fifo_level;

   // reference state: 0 idle, 1 prime, 2 run
   int                  m_state;
   int                  m_cnt;
   bit                  m_clk;
   logic [DATA_W-1:0]   m_out;
   bit                  m_under;
   logic [DATA_W-1:0]   exp_q [$];

   int                  n_checks = 0;
   int                  n_errors = 0;
   bit                  have_prev = 1'b0;
   logic [DATA_W-1:0]   prev_out;
   logic                prev_clk;

   dac_module #(
      .DATA_W        (DATA_W),
      .CLK_DIV       (CLK_DIV),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .PRIME_SAMPLES (PRIME_SAMPLES),
      .MIDSCALE      (MIDSCALE)
   ) dut (
      .clk_PSRAM    (clk_PSRAM),
      .rst          (rst),
      .dac_enable   (dac_enable),
      .dac_valid    (dac_valid),
      .dac_in       (dac_in),
      .dac_ready    (dac_ready),
      .clk_DAC      (clk_DAC),
      .dac_out      (dac_out),
      .dac_running  (dac_running),
      .dac_underrun (dac_underrun),
      .fifo_level   (fifo_level)
   );

   // free-running system clock
   always #5 clk_PSRAM = ~clk_PSRAM;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_ready();
      return dac_enable && !rst && (exp_q.size() < FIFO_DEPTH);
   endfunction

   task automatic compare_all();
      check_eq("ready",    dac_ready,    model_ready());
      check_eq("clk_dac",  clk_DAC,      m_clk);
      check_eq("dac_out",  dac_out,      m_out);
      check_eq("running",  dac_running,  (m_state == 2));
      check_eq("underrun", dac_underrun, m_under);
      check_eq("level",    fifo_level,   exp_q.size());
      // a newly played sample must appear exactly as clk_DAC falls
      if (have_prev && (dac_out !== prev_out) && (dac_out !== MIDSCALE)) begin
         check_eq("out_on_fall", {30'd0, prev_clk, clk_DAC}, 32'h2);
      end
      prev_out  = dac_out;
      prev_clk  = clk_DAC;
      have_prev = 1'b1;
   endtask

   task automatic model_step();
      bit rdy;
      bit push;
      bit fall;
      bit pop;
      int sz;
      sz   = exp_q.size();
      rdy  = model_ready();
      push = dac_valid && rdy;
      if (rst) begin
         m_state = 0; m_cnt = 0; m_clk = 1'b0; m_out = MIDSCALE; m_under = 1'b0;
         exp_q.delete();
      end else if (!dac_enable) begin
         m_state = 0; m_cnt = 0; m_clk = 1'b0; m_out = MIDSCALE;
         exp_q.delete();
      end else if (m_state == 0) begin
         m_state = 1;
         m_under = 1'b0;
         if (push) exp_q.push_back(dac_in);
      end else begin
         fall = (m_cnt == CLK_DIV - 1);
         pop  = fall && (((m_state == 2) && (sz > 0)) ||
                         ((m_state == 1) && (sz >= PRIME_SAMPLES)));
         if (fall) begin
            m_cnt = 0;
            m_clk = 1'b0;
         end else begin
            m_cnt++;
            if (m_cnt == CLK_DIV / 2) m_clk = 1'b1;
         end
         if (pop) begin
            m_out   = exp_q.pop_front();
            m_state = 2;
         end else if (fall && (m_state == 2)) begin
            m_under = 1'b1;
         end
         if (push) exp_q.push_back(dac_in);
      end
   endtask

   // one clk_PSRAM cycle: check current outputs, advance reference, cross edge
   task automatic tick();
      #1;
      compare_all();
      model_step();
      @(posedge clk_PSRAM);
      #1;
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      bit acc;
      int waited;
      acc    = 1'b0;
      waited = 0;
      dac_valid = 1'b1;
      dac_in    = d;
      while (!acc && (waited < 100)) begin
         acc = model_ready();
         tick();
         waited++;
      end
      check_eq("push_accept", acc, 1'b1);
      dac_valid = 1'b0;
   endtask

   initial begin
      bit                reached;
      bit                acc;
      int                guard;
      logic [DATA_W-1:0] data;

      rst = 1'b1; dac_enable = 1'b0; dac_valid = 1'b0; dac_in = '0;
      m_state = 0; m_cnt = 0; m_clk = 1'b0; m_out = MIDSCALE; m_under = 1'b0;
      @(posedge clk_PSRAM);
      #1;

      // reset state
      check_eq("rst_ready",    dac_ready,    1'b0);
      check_eq("rst_clk",      clk_DAC,      1'b0);
      check_eq("rst_out",      dac_out,      12'h800);
      check_eq("rst_running",  dac_running,  1'b0);
      check_eq("rst_underrun", dac_underrun, 1'b0);
      check_eq("rst_level",    fifo_level,   5'd0);
      tick();
      tick();

      // enabled with no data: divider runs, output parked at midscale
      rst = 1'b0; dac_enable = 1'b1;
      repeat (24) tick();
      check_eq("prime_running", dac_running, 1'b0);
      check_eq("prime_out",     dac_out,     12'h800);

      // four back-to-back samples prime and play
      for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
      repeat (24) tick();
      check_eq("play_last",     dac_out,      12'h004);
      check_eq("play_underrun", dac_underrun, 1'b1);
      check_eq("play_running",  dac_running,  1'b1);

      // reach level 5 in RUN, then drop enable for one cycle
      data = 12'h010; guard = 0;
      while ((exp_q.size() != 5) && (guard < 50)) begin
         push_word(data);
         data  = data + 12'h001;
         guard++;
      end
      check_eq("lvl5_reached", exp_q.size(), 5);
      check_eq("lvl5_dut", fifo_level, 5'd5);
      dac_enable = 1'b0;
      tick();
      check_eq("stop_level",    fifo_level,   5'd0);
      check_eq("stop_clk",      clk_DAC,      1'b0);
      check_eq("stop_out",      dac_out,      12'h800);
      check_eq("stop_underrun", dac_underrun, 1'b1);
      check_eq("stop_running",  dac_running,  1'b0);
      dac_enable = 1'b1;
      tick();
      check_eq("restart_underrun", dac_underrun, 1'b0);

      // hold valid until the FIFO fills while playback drains slowly
      data = 12'h100; guard = 0;
      dac_valid = 1'b1; dac_in = data;
      while ((exp_q.size() != FIFO_DEPTH) && (guard < 200)) begin
         acc = model_ready();
         tick();
         if (acc) begin data = data + 12'h001; dac_in = data; end
         guard++;
      end
      check_eq("full_level", fifo_level, 5'd16);
      #1;
      check_eq("full_ready", dac_ready, 1'b0);
      // wait for a full FIFO at a fall boundary: push refused, pop taken
      reached = 1'b0; guard = 0;
      while (!reached && (guard < 16)) begin
         reached = (exp_q.size() == FIFO_DEPTH) && (m_cnt == CLK_DIV - 1);
         acc = model_ready();
         tick();
         if (acc) begin data = data + 12'h001; dac_in = data; end
         guard++;
      end
      check_eq("full_fall_found", reached, 1'b1);
      check_eq("full_pushpop_level", fifo_level, 5'd15);
      acc = model_ready();
      tick();
      check_eq("held_sample_taken", acc, 1'b1);
      check_eq("refill_level", fifo_level, 5'd16);
      dac_valid = 1'b0;

      // drain to level 3 in RUN, then reset
      guard = 0;
      while ((exp_q.size() != 3) && (guard < 200)) begin
         tick();
         guard++;
      end
      check_eq("lvl3_dut", fifo_level, 5'd3);
      rst = 1'b1;
      tick();
      check_eq("mrst_ready",    dac_ready,    1'b0);
      check_eq("mrst_clk",      clk_DAC,      1'b0);
      check_eq("mrst_out",      dac_out,      12'h800);
      check_eq("mrst_running",  dac_running,  1'b0);
      check_eq("mrst_underrun", dac_underrun, 1'b0);
      check_eq("mrst_level",    fifo_level,   5'd0);
      rst = 1'b0;

      // three fresh samples are not enough to start
      push_word(12'h0A1);
      push_word(12'h0A2);
      push_word(12'h0A3);
      repeat (16) tick();
      check_eq("reprime_running", dac_running, 1'b0);
      check_eq("reprime_out",     dac_out,     12'h800);
      push_word(12'h0A4);
      repeat (CLK_DIV) tick();
      check_eq("restart_running", dac_running, 1'b1);
      check_eq("restart_first",   dac_out,     12'h0A1);

      dac_enable = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dac_module.md
Name: dac_module

Overview:
- Output-side counterpart of the ADC capture path: accepts 12-bit samples in the clk_PSRAM domain over a valid/ready handshake and buffers them in a small FIFO.
- Generates the DAC sample clock clk_DAC by dividing clk_PSRAM.
- Presents one sample per clk_DAC period: data changes on the clk_DAC falling edge and is stable at the rising edge, where the DAC latches it.
- Sits between the PSRAM read sequencer and the DAC pins (signal playback / stimulus generation).

Parameters:
- DATA_W, 12, sample width.
- CLK_DIV, 4, clk_PSRAM cycles per clk_DAC period; even, >= 2.
- FIFO_DEPTH, 16, sample buffer entries; power of 2.
- PRIME_SAMPLES, 4, FIFO level required before output starts; 1..FIFO_DEPTH.
- MIDSCALE, 12'h800, idle/priming output code.

Ports:
- clk_PSRAM  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- dac_enable  in  1  1 = play; 0 = stop and flush.
- dac_valid  in  1  dac_in holds a sample.
- dac_in  in  DATA_W  sample to play.
- dac_ready  out  1  FIFO can accept a sample this cycle.
- clk_DAC  out  1  divided DAC sample clock.
- dac_out  out  DATA_W  data to DAC pins.
- dac_running  out  1  FSM in RUN.
- dac_underrun  out  1  sticky: a pop was attempted on an empty FIFO.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values: dac_ready=0, clk_DAC=0, dac_out=MIDSCALE, dac_running=0, dac_underrun=0, fifo_level=0. FSM=IDLE, divider cnt=0, FIFO pointers=0.
- Push:
  - dac_ready = dac_enable && !rst && level<FIFO_DEPTH; combinational from registered level.
  - A push occurs when dac_valid && dac_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
- Divider: runs only in PRIME and RUN; cnt counts 0..CLK_DIV-1 and wraps.
  - Registered clk_DAC goes 1 in the cycle cnt becomes CLK_DIV/2.
  - clk_DAC goes 0 in the cycle cnt wraps to 0, the "fall boundary".
  - Duty cycle is 50%.
- FSM:
  - IDLE: cnt=0, clk_DAC=0, dac_out=MIDSCALE, FIFO empty. dac_enable=1 -> PRIME, and dac_underrun clears on this transition.
  - PRIME: divider running, dac_out=MIDSCALE. When level >= PRIME_SAMPLES at a fall boundary -> RUN, and the head sample is popped to dac_out in that same cycle.
  - RUN: dac_running=1. At every fall boundary, pop the head into dac_out.
    - If the FIFO is empty: dac_out holds its previous value, dac_underrun<=1, and the state stays RUN (no re-prime).
    - No pops at any other cnt value.
  - Any state, dac_enable=0: next cycle -> IDLE. The FIFO is flushed (pointers and level to 0), clk_DAC=0, dac_out=MIDSCALE, and dac_underrun is kept.
- Latency: a sample pushed into an empty FIFO in RUN at cycle t appears on dac_out at the first fall boundary strictly after t. dac_out is then stable for CLK_DIV cycles, with the clk_DAC rising edge CLK_DIV/2 cycles after the change.
- Reset mid-operation: all state returns to reset values in the next cycle and buffered samples are discarded.
- Width: pointers wrap modulo FIFO_DEPTH; level is one bit wider so that FIFO_DEPTH is representable.

Test Plan:
- rst=1 then dac_enable=1 with no pushes (CLK_DIV=4) -> clk_DAC toggles with period 4 (2 high, 2 low); dac_out=12'h800; dac_running=0 indefinitely.
- Push 12'h001..12'h004 back-to-back -> RUN entered at the next fall boundary. dac_out steps 001,002,003,004, each change coincident with a clk_DAC falling edge and 4 cycles apart.
- After the last sample plays, with no more pushes -> dac_out holds 12'h004, dac_underrun=1 at the next fall boundary, dac_running stays 1.
- Hold dac_valid=1 with the FIFO not draining (PRIME_SAMPLES=16, push 17 samples) -> dac_ready drops at level 16 and the 17th sample is held until dac_ready reasserts. Test push+pop in the same cycle while full: push refused, level 16->15.
- In RUN with level 5, drop dac_enable for 1 cycle -> next cycle: IDLE, fifo_level=0, clk_DAC=0, dac_out=12'h800, dac_underrun unchanged.
- rst asserted mid-RUN with level 3 -> next cycle all outputs at reset values. After re-enable, output starts only after PRIME_SAMPLES fresh pushes.
